// File: rtl/display_pkg.sv
// Shared types and glyph tables for the seven-segment scan driver.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   digit_t    - scan position, DIG0 is the rightmost digit
//   SEG_BLANK  - all segments off (active-low)
//   SEG_HEX    - active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F
//   anode_on   - active-low one-hot anode pattern for a scan position
package display_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Index = nibble value; bit 6 is segment g, bit 0 is segment a; 0 = lit.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40,  // 0
    7'h79,  // 1
    7'h24,  // 2
    7'h30,  // 3
    7'h19,  // 4
    7'h12,  // 5
    7'h02,  // 6
    7'h78,  // 7
    7'h00,  // 8
    7'h10,  // 9
    7'h08,  // A
    7'h03,  // b
    7'h46,  // C
    7'h21,  // d
    7'h06,  // E
    7'h0E   // F
  };

  function automatic logic [3:0] anode_on(input digit_t d);
    logic [3:0] onehot;
    onehot = 4'b0001 << d;
    return ~onehot;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Nibble to active-low seven-segment glyph decoder.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   nibble  in   4  hex digit to render
//   seg     out  7  {g,f,e,d,c,b,a}, active-low; every nibble value has a glyph
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scan driver with blanking gap per digit slot.
// Latency: 1 clk from value/slot state to pins; a load shows up from the following cycle on.
// Backpressure: none; load is accepted every cycle (held high = transparent).
//
// Ports:
//   clk        in   1   system clock
//   reset_n    in   1   asynchronous active-low reset
//   data_in    in   16  value to display, [3:0] = rightmost digit
//   load       in   1   capture data_in / dp_in on this edge
//   dp_in      in   4   per-digit decimal point request, active-high
//   seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1   decimal point, active-low
//   an         out  4   digit anodes, active-low
//   scan_tick  out  1   one-cycle pulse when the slot counter wraps
//
// Build option: define LZ_BLANK_EN to keep leading-zero digits (other than
// digit 0) dark. Slot timing is identical either way.
module hex_scan_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        scan_tick
);

  localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [15:0]      value_q;
  logic [3:0]       dpreq_q;
  logic [CNT_W-1:0] cnt_q;
  digit_t           digit_q;
  digit_t           digit_d;

  logic             wrap;
  logic [3:0]       nibble;
  logic             dp_sel;
  logic [6:0]       glyph;
  logic             dark;
  logic             in_gap;

  logic [6:0]       seg_d;
  logic             dp_d;
  logic [3:0]       an_d;

  // ---------------------------------------------------------------
  // Display value: single register so value and digit index always
  // come from the same snapshot, even when load lands on a wrap.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= 16'h0000;
      dpreq_q <= 4'h0;
    end else if (load) begin
      value_q <= data_in;
      dpreq_q <= dp_in;
    end
  end

  // ---------------------------------------------------------------
  // Slot counter
  // ---------------------------------------------------------------
  assign wrap = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Digit FSM: advances exactly once per slot wrap.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= DIG0;
    end else begin
      digit_q <= digit_d;
    end
  end

  always_comb begin
    digit_d = digit_q;
    if (wrap) begin
      case (digit_q)
        DIG0:    digit_d = DIG1;
        DIG1:    digit_d = DIG2;
        DIG2:    digit_d = DIG3;
        DIG3:    digit_d = DIG0;
        default: digit_d = DIG0;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Nibble / decimal-point select for the current digit
  // ---------------------------------------------------------------
  always_comb begin
    nibble = value_q[3:0];
    dp_sel = dpreq_q[0];
    case (digit_q)
      DIG0: begin nibble = value_q[3:0];   dp_sel = dpreq_q[0]; end
      DIG1: begin nibble = value_q[7:4];   dp_sel = dpreq_q[1]; end
      DIG2: begin nibble = value_q[11:8];  dp_sel = dpreq_q[2]; end
      DIG3: begin nibble = value_q[15:12]; dp_sel = dpreq_q[3]; end
      default: begin nibble = value_q[3:0]; dp_sel = dpreq_q[0]; end
    endcase
  end

  hex_to_7seg u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  // A digit is a leading zero when it and every digit to its left are 0.
  // Digit 0 is never suppressed so a zero value still shows "0".
`ifdef LZ_BLANK_EN
  always_comb begin
    dark = 1'b0;
    case (digit_q)
      DIG0:    dark = 1'b0;
      DIG1:    dark = (value_q[15:4]  == 12'h000);
      DIG2:    dark = (value_q[15:8]  == 8'h00);
      DIG3:    dark = (value_q[15:12] == 4'h0);
      default: dark = 1'b0;
    endcase
  end
`else
  assign dark = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Output stage. Every slot starts with cnt = 0 inside the gap, so the
  // last lit cycle of one digit is always followed by at least one fully
  // dark cycle before the next digit's anode drops.
  // ---------------------------------------------------------------
  assign in_gap = (cnt_q < BLANK_END);

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!in_gap && !dark) begin
      an_d  = anode_on(digit_q);
      seg_d = glyph;
      dp_d  = ~dp_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
      an        <= AN_OFF;
      scan_tick <= 1'b0;
    end else begin
      seg       <= seg_d;
      dp        <= dp_d;
      an        <= an_d;
      scan_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed self-checking bench for hex_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_hex_scan_driver;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;

  logic        clk;
  logic        reset_n;
  logic [15:0] data_in;
  logic        load;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        scan_tick;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;          // rising edges since last reset release

  logic [15:0] m_val;        // value the display should currently show
  logic [3:0]  m_dp;

  hex_scan_driver #(
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .load      (load),
    .dp_in     (dp_in),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .scan_tick (scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived active-low {g,f,e,d,c,b,a} glyphs.
  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, ecnt, obs, exp);
    end
  endtask

  // Outputs after edge e show the state before that edge:
  // slot position (e-1)%8, digit ((e-1)/8)%4.
  task automatic check_outputs();
    int c, d, k;
    logic lit;
    logic [3:0] nib;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    c   = (ecnt - 1) % RDIV;
    d   = ((ecnt - 1) / RDIV) % 4;
    lit = (c >= BLANK);
`ifdef LZ_BLANK_EN
    if (d >= 1) begin
      k = 0;
      for (int i = 4 * d; i < 16; i++) if (m_val[i]) k++;
      if (k == 0) lit = 1'b0;
    end
`endif
    nib     = 4'((m_val >> (4 * d)) & 16'hF);
    exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
    exp_seg = lit ? glyph_of(nib) : 7'h7F;
    exp_dp  = lit ? ~m_dp[d] : 1'b1;
    chk("an",        {12'h0, an},        {12'h0, exp_an});
    chk("seg",       {9'h0, seg},        {9'h0, exp_seg});
    chk("dp",        {15'h0, dp},        {15'h0, exp_dp});
    chk("scan_tick", {15'h0, scan_tick}, {15'h0, (c == RDIV - 1)});
  endtask

  task automatic tick();
    logic        ld;
    logic [15:0] nv;
    logic [3:0]  nd;
    @(posedge clk);
    ld = load; nv = data_in; nd = dp_in;
    ecnt++;
    #1;
    check_outputs();
    if (ld) begin
      m_val = nv;
      m_dp  = nd;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Never more than one anode low, on any cycle.
  always @(negedge clk) begin
    checks++;
    assert ($countones(~an) <= 1) else begin
      failures++;
      $error("FAIL anode_onehot observed=%b expected=at most one low", an);
    end
  end

  initial begin
    reset_n = 1'b1;
    load    = 1'b0;
    data_in = 16'h0000;
    dp_in   = 4'h0;
    m_val   = 16'h0000;
    m_dp    = 4'h0;
    #2 reset_n = 1'b0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg",  {9'h0, seg},        16'h007F);
    chk("rst_an",   {12'h0, an},        16'h000F);
    chk("rst_dp",   {15'h0, dp},        16'h0001);
    chk("rst_tick", {15'h0, scan_tick}, 16'h0000);

    // Release with a load of 1234 pending on the first edge.
    data_in = 16'h1234;
    load    = 1'b1;
    reset_n = 1'b1;
    ecnt    = 0;
    tick();
    load = 1'b0;
    tick();
    chk("post_rst_blank_an", {12'h0, an}, 16'h000F);

    // 2: 1234 scans E,D,B,7 with glyphs 4,3,2,1
    for (int i = 0; i < 32; i++) begin
      tick();
      if (ecnt == 3)  chk("d0_glyph4", {9'h0, seg}, 16'h0019);
      if (ecnt == 8)  chk("tick_at_8", {15'h0, scan_tick}, 16'h0001);
      if (ecnt == 11) chk("d1_an",     {12'h0, an}, 16'h000D);
      if (ecnt == 19) chk("d2_glyph2", {9'h0, seg}, 16'h0024);
      if (ecnt == 27) chk("d3_an",     {12'h0, an}, 16'h0007);
    end

    // 3: ABCD with decimal point on digit 2
    data_in = 16'hABCD;
    dp_in   = 4'b0100;
    load    = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (((ecnt - 1) % RDIV) == 4 && ((ecnt - 1) / RDIV) % 4 == 2) begin
        chk("abcd_d2_seg_b", {9'h0, seg}, 16'h0003);
        chk("abcd_d2_dp",    {15'h0, dp}, 16'h0000);
      end
      if (((ecnt - 1) % RDIV) == 4 && ((ecnt - 1) / RDIV) % 4 == 0) begin
        chk("abcd_d0_seg_d", {9'h0, seg}, 16'h0021);
        chk("abcd_d0_dp",    {15'h0, dp}, 16'h0001);
      end
    end

    // 4: load coincident with slot wrap
    for (int i = 0; i < RDIV && (ecnt % RDIV) != RDIV - 1; i++) tick();
    data_in = 16'h00F0;
    dp_in   = 4'b0000;
    load    = 1'b1;
    tick();
    load = 1'b0;
    run(32);

    // Transparent mode: load held high while data changes.
    load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      data_in = 16'h1111 * (i % 16);
      dp_in   = 4'(i);
      tick();
    end
    load = 1'b0;
    run(4);

    // 5: leading-zero behaviour (all digits lit unless LZ_BLANK_EN)
    data_in = 16'h0007;
    load    = 1'b1;
    tick();
    load = 1'b0;
    run(32);
    data_in = 16'h0000;
    load    = 1'b1;
    tick();
    load = 1'b0;
    run(32);

    // 6: reset pulse during digit 2 lit phase
    data_in = 16'h5678;
    load    = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (((ecnt - 1) % RDIV) >= BLANK && ((ecnt - 1) / RDIV) % 4 == 2) break;
      tick();
    end
    chk("pre_rst_d2_an", {12'h0, an}, 16'h000B);
    reset_n = 1'b0;
    #1;
    chk("async_rst_an",  {12'h0, an},  16'h000F);
    chk("async_rst_seg", {9'h0, seg},  16'h007F);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ecnt    = 0;
    m_val   = 16'h0000;
    m_dp    = 4'h0;
    run(12);
    chk("restart_d1_an", {12'h0, an}, 16'h000D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
